// File: rtl/risc_fetch_unit.sv
// -----------------------------------------------------------------------------
// risc_fetch_unit
//
// Instruction fetch front end. Holds the PC, issues word reads to a
// synchronous instruction memory (1-cycle read latency), buffers the returned
// words in a 2-entry queue and presents the head entry to the decoder on a
// valid/ready interface. Supports branch redirect with flush and stops
// fetching once a HALT opcode is returned.
//
// Parameters
//   PC_W      PC / instruction-memory byte-address width
//   RESET_PC  PC loaded on reset (word aligned)
//   HALT_OP   opcode that stops fetching
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous, active-high reset
//   imem_en        read strobe to instruction memory
//   imem_addr      word-aligned byte address of the read
//   imem_rdata     read data, valid the cycle after imem_en=1
//   instr_valid    head-of-queue instruction is available
//   instr_ready    decoder accepts the head this cycle
//   instr          head instruction word
//   opcode         instr[31:26]
//   instr_pc       PC of the head instruction
//   branch_taken   one-cycle redirect request
//   branch_target  redirect PC (bits [1:0] ignored)
//   halted         fetcher is in the HALTED state
// -----------------------------------------------------------------------------
module risc_fetch_unit #(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [5:0]      HALT_OP  = 6'b111111
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_en,
   output logic [PC_W-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr,
   output logic [5:0]      opcode,
   output logic [PC_W-1:0] instr_pc,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   output logic            halted
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t          r_state;
   logic [PC_W-1:0] r_pc;
   logic            r_inflight;     // a read was issued last cycle; data is on imem_rdata now
   logic [PC_W-1:0] r_inflight_pc;  // PC of that read
   logic [1:0]      r_count;        // queue occupancy, 0..2
   logic [31:0]     r_q_instr [2];  // entry 0 is always the head
   logic [PC_W-1:0] r_q_pc    [2];

   // ---------------------------------------------------------------------------
   // Control
   // ---------------------------------------------------------------------------
   state_t          w_next_state;
   logic            w_push;
   logic            w_pop;
   logic            w_issue;
   logic            w_halt_hit;
   logic [2:0]      w_slots;
   logic [5:0]      w_ret_op;
   logic [PC_W-1:0] w_target;

   // Low two bits of the target are masked rather than sliced so the whole
   // port stays in use.
   assign w_target = branch_target & ~PC_W'(3);
   assign w_ret_op = imem_rdata[31:26];

   // NOTE: every signal written here gets a default first, so no path through
   // the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      w_push       = 1'b0;
      w_pop        = 1'b0;
      w_issue      = 1'b0;
      w_halt_hit   = 1'b0;
      w_slots      = {1'b0, r_count} + {2'b00, r_inflight};

      // A returning read is kept only while still fetching and not being
      // flushed. A read issued in the cycle HALT was detected returns in
      // HALTED and is dropped here, which is how it gets squashed.
      w_push     = r_inflight && (r_state == S_FETCH) && !branch_taken;
      w_halt_hit = w_push && (w_ret_op == HALT_OP);

      // Redirect has priority over pop, enqueue and issue.
      w_pop = (r_count != 2'd0) && instr_ready && !branch_taken;

      // Queue entries plus the in-flight read must stay within 2 after this
      // cycle. The slot freed by a pop in this same cycle is counted, which
      // keeps one instruction per cycle flowing while the decoder is ready.
      if ((r_state == S_FETCH) && !branch_taken &&
          (w_slots < (3'd2 + {2'b00, w_pop}))) begin
         w_issue = 1'b1;
      end

      unique case (r_state)
         S_IDLE:   w_next_state = S_FETCH;
         S_FETCH: begin
            if (branch_taken)    w_next_state = S_FETCH;
            else if (w_halt_hit) w_next_state = S_HALTED;
         end
         S_HALTED: begin
            if (branch_taken) w_next_state = S_FETCH;
         end
         default:  w_next_state = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // ---------------------------------------------------------------------------
   // PC and in-flight tag
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else begin
         if (branch_taken) r_pc <= w_target;
         else if (w_issue) r_pc <= r_pc + PC_W'(4);  // wraps modulo 2^PC_W

         r_inflight <= w_issue;
         if (w_issue) r_inflight_pc <= r_pc;
      end
   end

   // ---------------------------------------------------------------------------
   // 2-entry shift queue: entry 0 is the head, entry 1 the tail when full.
   // A flush only clears the count; stale data stays behind invisibly, and the
   // head outputs keep their last value while empty.
   // ---------------------------------------------------------------------------
   // NOTE: the two queue entries are reset because the head drives the
   // instruction outputs directly and those must read 0 out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count      <= 2'd0;
         r_q_instr[0] <= '0;
         r_q_instr[1] <= '0;
         r_q_pc[0]    <= '0;
         r_q_pc[1]    <= '0;
      end else if (branch_taken) begin
         r_count <= 2'd0;
      end else begin
         unique case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) begin
                  r_q_instr[0] <= imem_rdata;
                  r_q_pc[0]    <= r_inflight_pc;
               end else begin
                  r_q_instr[1] <= imem_rdata;
                  r_q_pc[1]    <= r_inflight_pc;
               end
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               if (r_count == 2'd2) begin
                  r_q_instr[0] <= r_q_instr[1];
                  r_q_pc[0]    <= r_q_pc[1];
               end
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd2) begin
                  r_q_instr[0] <= r_q_instr[1];
                  r_q_pc[0]    <= r_q_pc[1];
                  r_q_instr[1] <= imem_rdata;
                  r_q_pc[1]    <= r_inflight_pc;
               end else begin
                  r_q_instr[0] <= imem_rdata;
                  r_q_pc[0]    <= r_inflight_pc;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign imem_en     = w_issue;
   assign imem_addr   = r_pc;
   assign instr_valid = (r_count != 2'd0);
   assign instr       = r_q_instr[0];
   assign opcode      = r_q_instr[0][31:26];
   assign instr_pc    = r_q_pc[0];
   assign halted      = (r_state == S_HALTED);

endmodule

// File: tb/tb_risc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_risc_fetch_unit
//
// Directed bench for risc_fetch_unit. A behavioural synchronous memory returns
// word (addr>>2) at every address, optionally with a HALT word at 0x000C.
// Expected delivered PCs are pushed to a scoreboard as stimulus is driven; a
// monitor pops and compares on every accepted instruction.
// -----------------------------------------------------------------------------
module tb_risc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_en;
   logic [15:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [15:0] instr_pc;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_target = '0;
   logic        halted;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_q[$];
   bit          halt_en = 1'b0;

   risc_fetch_unit #(
      .PC_W     (16),
      .RESET_PC (16'h0000),
      .HALT_OP  (6'b111111)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_en       (imem_en),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .opcode        (opcode),
      .instr_pc      (instr_pc),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      if (halt_en && (a == 16'h000C)) return 32'hFC00_0000;
      return {18'b0, a[15:2]};
   endfunction

   // Synchronous instruction memory, 1-cycle read latency.
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= mem_word(imem_addr);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Scoreboard monitor: every accepted instruction must match the next
   // expected PC and the model's word for that PC.
   always @(negedge clk) begin
      logic [15:0] e;
      logic [31:0] w;
      if (!rst && instr_valid && instr_ready && !branch_taken) begin
         n_tests++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_unexpected: observed pc %h expected none", instr_pc);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            w = mem_word(e);
            check("sb_pc", {16'h0, instr_pc}, {16'h0, e});
            check("sb_instr", instr, w);
            check("sb_opcode", {26'h0, opcode}, {26'h0, w[31:26]});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset state ----------------
      #2;
      check("rst_valid",  {31'h0, instr_valid}, 32'h0);
      check("rst_en",     {31'h0, imem_en},     32'h0);
      check("rst_addr",   {16'h0, imem_addr},   32'h0);
      check("rst_halted", {31'h0, halted},      32'h0);
      check("rst_instr",  instr,                32'h0);
      check("rst_opcode", {26'h0, opcode},      32'h0);
      check("rst_pc",     {16'h0, instr_pc},    32'h0);

      // ---------------- backpressure from reset ----------------
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      check("bp_en1",    {31'h0, imem_en},     32'h1);
      check("bp_addr1",  {16'h0, imem_addr},   32'h0000);
      check("bp_valid1", {31'h0, instr_valid}, 32'h0);
      @(negedge clk);
      check("bp_en2",    {31'h0, imem_en},     32'h1);
      check("bp_addr2",  {16'h0, imem_addr},   32'h0004);
      check("bp_valid2", {31'h0, instr_valid}, 32'h0);
      @(negedge clk);
      check("bp_first_valid", {31'h0, instr_valid}, 32'h1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_hold_en",    {31'h0, imem_en},     32'h0);
         check("bp_hold_valid", {31'h0, instr_valid}, 32'h1);
         check("bp_hold_pc",    {16'h0, instr_pc},    32'h0000);
      end

      // ---------------- stream at one per cycle ----------------
      @(posedge clk); #1;
      instr_ready = 1'b1;
      for (int i = 0; i < 10; i++) exp_q.push_back(16'(4 * i));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stream_valid", {31'h0, instr_valid}, 32'h1);
      end

      // ---------------- redirect with an in-flight read ----------------
      @(posedge clk); #1;
      branch_taken  = 1'b1;
      branch_target = 16'h0043;
      @(negedge clk);
      check("br_no_issue", {31'h0, imem_en}, 32'h0);
      check("br_sb_drain", exp_q.size(),     32'h0);
      @(posedge clk); #1;
      branch_taken = 1'b0;
      exp_q.push_back(16'h0040);
      @(negedge clk);
      check("br_valid0", {31'h0, instr_valid}, 32'h0);
      check("br_en",     {31'h0, imem_en},     32'h1);
      check("br_addr",   {16'h0, imem_addr},   32'h0040);
      for (int i = 0; i < 8 && !instr_valid; i++) @(negedge clk);
      check("br_first_valid", {31'h0, instr_valid}, 32'h1);
      check("br_first_pc",    {16'h0, instr_pc},    32'h0040);
      @(posedge clk); #1;
      instr_ready = 1'b0;
      repeat (4) @(negedge clk);
      check("full_valid", {31'h0, instr_valid}, 32'h1);
      check("full_pc",    {16'h0, instr_pc},    32'h0044);
      check("full_en",    {31'h0, imem_en},     32'h0);

      // ---------------- async reset mid-stream ----------------
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_valid",  {31'h0, instr_valid}, 32'h0);
      check("arst_en",     {31'h0, imem_en},     32'h0);
      check("arst_halted", {31'h0, halted},      32'h0);
      check("arst_addr",   {16'h0, imem_addr},   32'h0000);

      // ---------------- HALT ----------------
      halt_en     = 1'b1;
      instr_ready = 1'b1;
      exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0004);
      exp_q.push_back(16'h0008);
      exp_q.push_back(16'h000C);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      check("restart_en",   {31'h0, imem_en},   32'h1);
      check("restart_addr", {16'h0, imem_addr}, 32'h0000);
      for (int i = 0; i < 20 && !halted; i++) @(negedge clk);
      check("halt_entered", {31'h0, halted}, 32'h1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("halt_no_issue", {31'h0, imem_en}, 32'h0);
         check("halt_stays",    {31'h0, halted},  32'h1);
      end
      check("halt_sb_drain", exp_q.size(), 32'h0);

      // ---------------- resume from HALTED ----------------
      @(posedge clk); #1;
      instr_ready   = 1'b0;
      branch_taken  = 1'b1;
      branch_target = 16'h0020;
      @(posedge clk); #1;
      branch_taken = 1'b0;
      @(negedge clk);
      check("resume_halted", {31'h0, halted},    32'h0);
      check("resume_en",     {31'h0, imem_en},   32'h1);
      check("resume_addr",   {16'h0, imem_addr}, 32'h0020);
      repeat (4) @(negedge clk);
      check("resume_valid", {31'h0, instr_valid}, 32'h1);
      check("resume_pc",    {16'h0, instr_pc},    32'h0020);
      check("resume_instr", instr,                mem_word(16'h0020));

      // ---------------- wrap, flushing a full queue ----------------
      @(posedge clk); #1;
      branch_taken  = 1'b1;
      branch_target = 16'hFFF8;
      instr_ready   = 1'b1;
      exp_q.push_back(16'hFFF8);
      exp_q.push_back(16'hFFFC);
      @(posedge clk); #1;
      branch_taken = 1'b0;
      @(negedge clk);
      check("wrap_addr0", {16'h0, imem_addr}, 32'hFFF8);
      @(negedge clk);
      check("wrap_addr1", {16'h0, imem_addr}, 32'hFFFC);
      @(negedge clk);
      check("wrap_addr2", {16'h0, imem_addr}, 32'h0000);
      check("wrap_en2",   {31'h0, imem_en},   32'h1);
      @(negedge clk);
      check("wrap_addr3", {16'h0, imem_addr}, 32'h0004);
      @(posedge clk); #1;
      instr_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("wrap_head_valid", {31'h0, instr_valid}, 32'h1);
      check("wrap_head_pc",    {16'h0, instr_pc},    32'h0000);
      check("wrap_sb_drain",   exp_q.size(),         32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
